// File: rtl/twiddle_pkg.sv
// Shared helpers for the twiddle rotator: rounding, saturation and the
// elaboration-time quarter-wave cosine table generator.
package twiddle_pkg;

    // Default configuration and the derived table/unity constants for it.
    localparam int DEF_LOG2_NFFT = 6;
    localparam int DEF_TW_W      = 16;
    localparam int QTR           = 2 ** (DEF_LOG2_NFFT - 2);
    localparam int ONE           = 2 ** (DEF_TW_W - 2);

    // pi/2 in Q30, used by the integer cosine series.
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_t;

    function automatic int qtr_of(int log2n);
        return 1 << (log2n - 2);
    endfunction

    function automatic int one_of(int tw_w);
        return 1 << (tw_w - 2);
    endfunction

    // Round half-up then drop 'shift' fraction bits.
    function automatic longint round_half_up(longint v, int shift);
        return (v + (longint'(1) <<< (shift - 1))) >>> shift;
    endfunction

    // Clamp to a signed 'width'-bit range, flagging when clamping happened.
    function automatic sat_t saturate(longint v, int width);
        sat_t   r;
        longint hi;
        longint lo;
        hi    = (longint'(1) <<< (width - 1)) - 1;
        lo    = -(longint'(1) <<< (width - 1));
        r.sat = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

    function automatic sat_t sat_add(longint a, longint b, int width);
        return saturate(a + b, width);
    endfunction

    // round(cos(2*pi*j/N) * 2^(tw_w-2)) using a Q30 Taylor series, so the
    // table is pure integer arithmetic at elaboration.
    function automatic int tw_entry(int j, int log2n, int tw_w);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (HALF_PI_Q30 * longint'(j)) / longint'(qtr_of(log2n));
        x2   = (x * x) >>> 30;
        term = longint'(1) <<< 30;
        acc  = term;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            acc  = acc + term;
        end
        return int'((acc * longint'(one_of(tw_w)) + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/twiddle_rotator_if.sv
// Sample-in / butterfly-pair-out stream bundle for the twiddle rotator.
interface twiddle_rotator_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LOG2_NFFT = 6
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;
    logic [LOG2_NFFT-2:0]     in_k;
    logic                     in_inv;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_p_i;
    logic signed [DATA_W-1:0] out_p_q;
    logic signed [DATA_W-1:0] out_m_i;
    logic signed [DATA_W-1:0] out_m_q;
    logic                     out_sat;

    modport master (
        output in_valid, in_i, in_q, in_k, in_inv, out_ready,
        input  in_ready, out_valid, out_p_i, out_p_q, out_m_i, out_m_q, out_sat
    );

    modport slave (
        input  in_valid, in_i, in_q, in_k, in_inv, out_ready,
        output in_ready, out_valid, out_p_i, out_p_q, out_m_i, out_m_q, out_sat
    );
endinterface

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table with folding to the half circle; registered
// cos/sin outputs form the first pipeline stage.
module twiddle_rom
    import twiddle_pkg::*;
#(
    parameter int unsigned TW_W      = 16,
    parameter int unsigned LOG2_NFFT = 6
) (
    input  logic                   clk,
    input  logic                   ce,
    input  logic [LOG2_NFFT-2:0]   k,
    output logic signed [TW_W-1:0] c,
    output logic signed [TW_W-1:0] s
);
    localparam int          Qtr = qtr_of(LOG2_NFFT);
    localparam int unsigned IW  = LOG2_NFFT - 1;

    logic signed [TW_W-1:0] tbl [Qtr+1];

    for (genvar j = 0; j <= Qtr; j++) begin : g_tbl
        localparam int Val = tw_entry(j, LOG2_NFFT, TW_W);
        assign tbl[j] = TW_W'(Val);
    end

    logic [IW-1:0]          k_prime;
    logic [IW-1:0]          idx_c;
    logic [IW-1:0]          idx_s;
    logic                   neg_c;
    logic signed [TW_W-1:0] c_d;
    logic signed [TW_W-1:0] s_d;

    // Fold k in (N/4, N/2) onto the quarter wave; cosine goes negative there.
    always_comb begin
        k_prime = k - IW'(Qtr);
        idx_c   = k;
        idx_s   = IW'(Qtr) - k;
        neg_c   = 1'b0;
        if (k > IW'(Qtr)) begin
            idx_c = IW'(Qtr) - k_prime;
            idx_s = k_prime;
            neg_c = 1'b1;
        end
        c_d = neg_c ? -tbl[idx_c] : tbl[idx_c];
        s_d = tbl[idx_s];
    end

    // Stage S1 twiddle register, held with the rest of the pipe.
    always_ff @(posedge clk) begin
        if (ce) begin
            c <= c_d;
            s <= s_d;
        end
    end

endmodule

// File: rtl/twiddle_rotator.sv
// Fully pipelined complex twiddle multiply producing both butterfly terms
// x*W and -x*W, with a single global stall enable for back-pressure.
module twiddle_rotator
    import twiddle_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TW_W      = 16,
    parameter int unsigned LOG2_NFFT = 6
) (
    input logic               clk,
    input logic               rst,
    twiddle_rotator_if.slave  bus
);
    localparam int unsigned PW = DATA_W + TW_W;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned Sh = TW_W - 2;

    logic ce;

    // S1 state
    logic                     v1_q;
    logic                     inv1_q;
    logic signed [DATA_W-1:0] a1_q;
    logic signed [DATA_W-1:0] b1_q;
    logic signed [TW_W-1:0]   c1;
    logic signed [TW_W-1:0]   s1;

    // S2 state
    logic                     v2_q;
    logic                     inv2_q;
    logic signed [PW-1:0]     ac_q;
    logic signed [PW-1:0]     bs_q;
    logic signed [PW-1:0]     bc_q;
    logic signed [PW-1:0]     as_q;

    // S3 state
    logic                     v3_q;
    logic                     sat3_q;
    logic signed [DATA_W-1:0] p3_i_q;
    logic signed [DATA_W-1:0] p3_q_q;

    // S4 / output state
    logic                     out_valid_q;
    logic                     out_sat_q;
    logic signed [DATA_W-1:0] out_p_i_q;
    logic signed [DATA_W-1:0] out_p_q_q;
    logic signed [DATA_W-1:0] out_m_i_q;
    logic signed [DATA_W-1:0] out_m_q_q;

    // Whole pipe advances unless a presented output is being refused.
    assign ce           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = ce && !rst;

    twiddle_rom #(
        .TW_W      (TW_W),
        .LOG2_NFFT (LOG2_NFFT)
    ) u_rom (
        .clk (clk),
        .ce  (ce),
        .k   (bus.in_k),
        .c   (c1),
        .s   (s1)
    );

    // S1 valid: a bubble enters whenever in_valid is low during an advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (ce) begin
            v1_q <= bus.in_valid;
        end
    end

    // S1 sample and direction capture, alongside the table read.
    always_ff @(posedge clk) begin
        if (ce) begin
            a1_q   <= bus.in_i;
            b1_q   <= bus.in_q;
            inv1_q <= bus.in_inv;
        end
    end

    logic signed [PW-1:0] ac_d;
    logic signed [PW-1:0] bs_d;
    logic signed [PW-1:0] bc_d;
    logic signed [PW-1:0] as_d;

    // Full-width signed partial products.
    always_comb begin
        ac_d = PW'(a1_q) * PW'(c1);
        bs_d = PW'(b1_q) * PW'(s1);
        bc_d = PW'(b1_q) * PW'(c1);
        as_d = PW'(a1_q) * PW'(s1);
    end

    // S2 product registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (ce) begin
            v2_q <= v1_q;
        end
    end

    // S2 datapath registers.
    always_ff @(posedge clk) begin
        if (ce) begin
            inv2_q <= inv1_q;
            ac_q   <= ac_d;
            bs_q   <= bs_d;
            bc_q   <= bc_d;
            as_q   <= as_d;
        end
    end

    logic signed [SW-1:0]     re_d;
    logic signed [SW-1:0]     im_d;
    sat_t                     pr_i;
    sat_t                     pr_q;
    logic signed [DATA_W-1:0] p_i_d;
    logic signed [DATA_W-1:0] p_q_d;
    logic                     sat_p_d;

    // Direction-dependent combine, round half-up and saturate P.
    always_comb begin
        if (inv2_q) begin
            re_d = SW'(ac_q) - SW'(bs_q);
            im_d = SW'(bc_q) + SW'(as_q);
        end else begin
            re_d = SW'(ac_q) + SW'(bs_q);
            im_d = SW'(bc_q) - SW'(as_q);
        end
        pr_i    = saturate(round_half_up(longint'(re_d), Sh), DATA_W);
        pr_q    = saturate(round_half_up(longint'(im_d), Sh), DATA_W);
        p_i_d   = DATA_W'(pr_i.val);
        p_q_d   = DATA_W'(pr_q.val);
        sat_p_d = pr_i.sat || pr_q.sat;
    end

    // S3 valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q <= 1'b0;
        end else if (ce) begin
            v3_q <= v2_q;
        end
    end

    // S3 saturated P and its saturation flag.
    always_ff @(posedge clk) begin
        if (ce) begin
            p3_i_q <= p_i_d;
            p3_q_q <= p_q_d;
            sat3_q <= sat_p_d;
        end
    end

    sat_t                     mr_i;
    sat_t                     mr_q;
    logic signed [DATA_W-1:0] m_i_d;
    logic signed [DATA_W-1:0] m_q_d;

    // Negate the already-saturated P; only the most negative code clips.
    always_comb begin
        mr_i  = sat_add(64'sd0, -longint'(p3_i_q), DATA_W);
        mr_q  = sat_add(64'sd0, -longint'(p3_q_q), DATA_W);
        m_i_d = DATA_W'(mr_i.val);
        m_q_d = DATA_W'(mr_q.val);
    end

    // S4 output registers; data only reloads on a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_p_i_q   <= '0;
            out_p_q_q   <= '0;
            out_m_i_q   <= '0;
            out_m_q_q   <= '0;
        end else if (ce) begin
            out_valid_q <= v3_q;
            if (v3_q) begin
                out_p_i_q <= p3_i_q;
                out_p_q_q <= p3_q_q;
                out_m_i_q <= m_i_d;
                out_m_q_q <= m_q_d;
                out_sat_q <= sat3_q || mr_i.sat || mr_q.sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_p_i   = out_p_i_q;
    assign bus.out_p_q   = out_p_q_q;
    assign bus.out_m_i   = out_m_i_q;
    assign bus.out_m_q   = out_m_q_q;

endmodule

// File: tb/tb_twiddle_rotator.sv
// Scoreboard bench for twiddle_rotator at N=8, 16-bit data and twiddles.
module tb_twiddle_rotator;
    localparam int DATA_W    = 16;
    localparam int TW_W      = 16;
    localparam int LOG2_NFFT = 3;

    typedef struct {
        logic signed [15:0] p_i;
        logic signed [15:0] p_q;
        logic signed [15:0] m_i;
        logic signed [15:0] m_q;
        logic               sat;
        int                 due;
        bit                 lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   last_pop = 0;
    bit   accepted;
    exp_t pending;
    exp_t sbq[$];

    always #5 clk = ~clk;

    twiddle_rotator_if #(.DATA_W(DATA_W), .LOG2_NFFT(LOG2_NFFT)) bus ();

    twiddle_rotator #(
        .DATA_W    (DATA_W),
        .TW_W      (TW_W),
        .LOG2_NFFT (LOG2_NFFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint clamp16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference product using floating-point trig for the twiddle.
    function automatic exp_t model(int a, int b, int k, bit inv);
        exp_t   e;
        real    th;
        longint c, s, re, im, pi, pq, mi, mq;
        th = 2.0 * 3.141592653589793 * real'(k) / 8.0;
        c  = longint'($rtoi($floor($cos(th) * 16384.0 + 0.5)));
        s  = longint'($rtoi($floor($sin(th) * 16384.0 + 0.5)));
        re = inv ? (a * c - b * s) : (a * c + b * s);
        im = inv ? (b * c + a * s) : (b * c - a * s);
        re = (re + 8192) >>> 14;
        im = (im + 8192) >>> 14;
        pi = clamp16(re);
        pq = clamp16(im);
        mi = clamp16(-pi);
        mq = clamp16(-pq);
        e.p_i = 16'(pi);
        e.p_q = 16'(pq);
        e.m_i = 16'(mi);
        e.m_q = 16'(mq);
        e.sat = (pi != re) || (pq != im) || (mi != -pi) || (mq != -pq);
        e.due = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(int pi, int pq, int mi, int mq, bit sat);
        exp_t e;
        e.p_i = 16'(pi);
        e.p_q = 16'(pq);
        e.m_i = 16'(mi);
        e.m_q = 16'(mq);
        e.sat = sat;
        e.due = 0;
        e.lat = 1'b1;
        return e;
    endfunction

    task automatic send(int a, int b, int k, bit inv, exp_t e);
        bus.in_valid = 1'b1;
        bus.in_i     = 16'(a);
        bus.in_q     = 16'(b);
        bus.in_k     = 2'(k);
        bus.in_inv   = inv;
        pending      = e;
    endtask

    // One clock: observe handshakes mid-cycle, then step past the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                last_pop = cyc;
                chk("sb_nonempty", (sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("p_i", bus.out_p_i, e.p_i);
                    chk("p_q", bus.out_p_q, e.p_q);
                    chk("m_i", bus.out_m_i, e.m_i);
                    chk("m_q", bus.out_m_q, e.m_q);
                    chk("sat", bus.out_sat, e.sat);
                    if (e.lat) chk("latency", cyc, e.due);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                accepted = 1'b1;
                e        = pending;
                e.due    = cyc + 4;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(int max);
        int n = 0;
        bus.in_valid = 1'b0;
        while (sbq.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        int   sa [8];
        int   sb [8];
        int   n_acc;
        int   s;
        int   rel_cyc;
        int   pop_base;

        bus.in_valid  = 1'b0;
        bus.in_i      = '0;
        bus.in_q      = '0;
        bus.in_k      = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_p_i", bus.out_p_i, 0);
        chk("rst_m_q", bus.out_m_q, 0);
        chk("rst_sat", bus.out_sat, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_idle", bus.in_ready, 1);

        // Directed twiddle cases, back to back, latency checked.
        send(1000, -2000, 0, 0, mk(1000, -2000, -1000, 2000, 0));
        tick();
        chk("acc0", accepted, 1);
        send(1000, -2000, 2, 0, mk(-2000, -1000, 2000, 1000, 0));
        tick();
        send(1000, -2000, 2, 1, mk(2000, 1000, -2000, -1000, 0));
        tick();
        send(16384, 0, 1, 0, mk(11585, -11585, -11585, 11585, 0));
        tick();
        send(16384, 0, 3, 0, mk(-11585, -11585, 11585, 11585, 0));
        tick();
        send(16384, 0, 1, 1, mk(11585, 11585, -11585, -11585, 0));
        tick();
        send(-32768, -32768, 0, 0, mk(-32768, -32768, 32767, 32767, 1));
        tick();
        send(32767, 32767, 1, 0, mk(32767, 0, -32767, 0, 1));
        tick();
        drain(20);

        // Back-pressure: 8 samples, out_ready low from stream cycle 2 to 10.
        for (int i = 0; i < 8; i++) begin
            sa[i] = int'($urandom_range(0, 65535)) - 32768;
            sb[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        sa[5] = 32767;
        sb[5] = 32767;
        n_acc    = 0;
        s        = 0;
        rel_cyc  = 0;
        pop_base = 0;
        while (n_acc < 8 && s < 60) begin
            if (s == 2) bus.out_ready = 1'b0;
            if (s == 10) begin
                bus.out_ready = 1'b1;
                rel_cyc       = cyc;
                pop_base      = n_pop;
            end
            send(sa[n_acc], sb[n_acc], n_acc % 4, n_acc[0],
                 model(sa[n_acc], sb[n_acc], n_acc % 4, n_acc[0]));
            tick();
            if (accepted) n_acc++;
            if (s == 6) begin
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_depth", n_acc, 4);
            end
            if (s == 8 && sbq.size() > 0) begin
                chk("held_p_i", bus.out_p_i, sbq[0].p_i);
                chk("held_m_q", bus.out_m_q, sbq[0].m_q);
            end
            s++;
        end
        chk("stream_accepted", n_acc, 8);
        drain(30);
        chk("stream_pops", n_pop - pop_base, 8);
        chk("stream_no_gap", last_pop, rel_cyc + 7);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            send(1000 * (i + 1), -500, i, 1'b0, model(1000 * (i + 1), -500, i, 1'b0));
            tick();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_p_i", bus.out_p_i, 0);
        chk("post_rst_p_q", bus.out_p_q, 0);
        chk("post_rst_m_i", bus.out_m_i, 0);
        chk("post_rst_sat", bus.out_sat, 0);
        repeat (6) tick();
        send(-1200, 700, 3, 1'b1, model(-1200, 700, 3, 1'b1));
        pending.lat = 1'b1;
        tick();
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
